// File: rtl/vec_pkg.sv
// Shared sizing, state and payload types for the vector join stage.
// Optional lane masking is enabled with the JOIN_LANE_MASK_EN macro.
package vec_pkg;

    localparam int unsigned DEF_N = 32;
    localparam int unsigned DEF_V = 20;
    localparam int unsigned DEF_L = 4;
    localparam int unsigned DEF_A = 5;

    function automatic int unsigned beats_for(input int unsigned v, input int unsigned l);
        return (v + l - 1) / l;
    endfunction

    function automatic int unsigned beat_w_for(input int unsigned beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int unsigned BEATS  = beats_for(DEF_V, DEF_L);
    localparam int unsigned BEAT_W = beat_w_for(BEATS);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } join_state_e;

    typedef logic [DEF_L-1:0][DEF_N-1:0] lane_chunk_t;

endpackage

// File: rtl/join_lane_bank.sv
// V x N element register bank; routes lane j of beat b into element b*L+j.
// With JOIN_LANE_MASK_EN defined, per-lane masking and a write-enable vector are added.
module join_lane_bank
    import vec_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned V  = DEF_V,
    parameter int unsigned L  = DEF_L,
    parameter int unsigned BW = beat_w_for(beats_for(DEF_V, DEF_L))
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [BW-1:0]        beat,
    input  logic [L-1:0][N-1:0]  chunk,
`ifdef JOIN_LANE_MASK_EN
    input  logic [L-1:0]         lane_mask,
    output logic [V-1:0]         we_mask,
`endif
    output logic [V-1:0][N-1:0]  data
);

    logic [L-1:0] lane_en;

`ifdef JOIN_LANE_MASK_EN
    assign lane_en = lane_mask;
`else
    assign lane_en = '1;
`endif

    // Each element owns a fixed (beat, lane) slot; lanes past V on the last beat have no element.
    for (genvar i = 0; i < V; i++) begin : g_elem
        localparam int unsigned LANE = i % L;
        localparam int unsigned SLOT = i / L;

        logic         hit;
        logic [N-1:0] q;

        assign hit = we && (beat == BW'(SLOT));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q <= '0;
            end else if (hit && lane_en[LANE]) begin
                q <= chunk[LANE];
            end
        end

        assign data[i] = q;

`ifdef JOIN_LANE_MASK_EN
        logic en_q;

        // Cleared by the first beat of a vector, then set by this element's own beat.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                en_q <= 1'b0;
            end else if (hit) begin
                en_q <= lane_en[LANE];
            end else if (we && (beat == '0)) begin
                en_q <= 1'b0;
            end
        end

        assign we_mask[i] = en_q;
`endif
    end

endmodule

// File: rtl/join_vector.sv
// Collects L-lane result chunks into a full V-element vector for register writeback.
// Define JOIN_LANE_MASK_EN to add lane_mask_i / WE_MASK_o.
module join_vector
    import vec_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned V = DEF_V,
    parameter int unsigned L = DEF_L,
    parameter int unsigned A = DEF_A
)(
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 abort_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [L-1:0][N-1:0]  chunk_i,
    input  logic [A-1:0]         addr_i,
`ifdef JOIN_LANE_MASK_EN
    input  logic [L-1:0]         lane_mask_i,
    output logic [V-1:0]         WE_MASK_o,
`endif
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [V-1:0][N-1:0]  WD_VEC_o,
    output logic [A-1:0]         wb_addr_o
);

    localparam int unsigned NUM_BEATS = beats_for(V, L);
    localparam int unsigned CNT_W     = beat_w_for(NUM_BEATS);

    join_state_e      state, state_next;
    logic [CNT_W-1:0] beat, beat_next;
    logic             ready_next;
    logic             valid_next;
    logic             accept;
    logic             addr_we;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= COLLECT;
            beat       <= '0;
            in_ready_o <= 1'b1;
            wb_valid_o <= 1'b0;
            wb_addr_o  <= '0;
        end else begin
            state      <= state_next;
            beat       <= beat_next;
            in_ready_o <= ready_next;
            wb_valid_o <= valid_next;
            if (addr_we) begin
                wb_addr_o <= addr_i;
            end
        end
    end

    // Abort outranks everything, including a beat offered in the same cycle.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        ready_next = in_ready_o;
        valid_next = wb_valid_o;
        accept     = 1'b0;
        addr_we    = 1'b0;

        if (abort_i) begin
            state_next = COLLECT;
            beat_next  = '0;
            ready_next = 1'b1;
            valid_next = 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    ready_next = 1'b1;
                    valid_next = 1'b0;
                    if (in_valid_i && in_ready_o) begin
                        accept  = 1'b1;
                        addr_we = (beat == '0);
                        if (beat == CNT_W'(NUM_BEATS - 1)) begin
                            state_next = HOLD;
                            beat_next  = '0;
                            ready_next = 1'b0;
                            valid_next = 1'b1;
                        end else begin
                            beat_next = beat + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    ready_next = 1'b0;
                    valid_next = 1'b1;
                    if (wb_ready_i) begin
                        state_next = COLLECT;
                        ready_next = 1'b1;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = COLLECT;
                    beat_next  = '0;
                    ready_next = 1'b1;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    join_lane_bank #(
        .N  (N),
        .V  (V),
        .L  (L),
        .BW (CNT_W)
    ) u_bank (
        .clk       (CLK),
        .rst       (RST),
        .we        (accept),
        .beat      (beat),
        .chunk     (chunk_i),
`ifdef JOIN_LANE_MASK_EN
        .lane_mask (lane_mask_i),
        .we_mask   (WE_MASK_o),
`endif
        .data      (WD_VEC_o)
    );

endmodule

// File: tb/tb_join_vector.sv
// Directed, table-driven bench for join_vector; mask checks run when JOIN_LANE_MASK_EN is defined.
module tb_join_vector;
    import vec_pkg::*;

    localparam int unsigned N = 32;
    localparam int unsigned V = 20;
    localparam int unsigned L = 4;
    localparam int unsigned A = 5;

    typedef struct {
        int           id;
        logic [A-1:0] addr;
        logic [N-1:0] base;
        int           gap;
        int           hold;
        logic [A-1:0] exp_addr;
    } vec_rec_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                abort = 1'b0;
    logic                in_valid = 1'b0;
    logic                wb_ready = 1'b0;
    logic                in_ready;
    logic                wb_valid;
    logic [L-1:0][N-1:0] chunk = '0;
    logic [A-1:0]        addr = '0;
    logic [V-1:0][N-1:0] wd;
    logic [A-1:0]        wb_addr;
`ifdef JOIN_LANE_MASK_EN
    logic [L-1:0]        lane_mask = '1;
    logic [V-1:0]        we_mask;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    join_vector dut (
        .CLK         (clk),
        .RST         (rst),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .chunk_i     (chunk),
        .addr_i      (addr),
`ifdef JOIN_LANE_MASK_EN
        .lane_mask_i (lane_mask),
        .WE_MASK_o   (we_mask),
`endif
        .wb_valid_o  (wb_valid),
        .wb_ready_i  (wb_ready),
        .WD_VEC_o    (wd),
        .wb_addr_o   (wb_addr)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [L-1:0][N-1:0] mk_chunk(input logic [N-1:0] base, input int k);
        logic [L-1:0][N-1:0] c;
        for (int j = 0; j < int'(L); j++) c[j] = base + N'(k * int'(L) + j);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Element i of a clean vector is base + i; report the lowest wrong element.
    task automatic chk_vec(input string name, input logic [N-1:0] base);
        int bad = 0;
        for (int i = int'(V) - 1; i >= 0; i--) if (wd[i] !== base + N'(i)) bad = i;
        chk(name, 64'(wd[bad]), 64'(base + N'(bad)));
    endtask

    task automatic run_vec(input vec_rec_t r);
        for (int k = 0; k < int'(BEATS); k++) begin
            chk($sformatf("v%0d_ready_b%0d", r.id, k), 64'(in_ready), 64'(1));
            in_valid = 1'b1;
            chunk    = mk_chunk(r.base, k);
            addr     = (k == 0) ? r.addr : ~r.addr;
            step();
            in_valid = 1'b0;
            chunk    = '0;
            chk($sformatf("v%0d_valid_b%0d", r.id, k), 64'(wb_valid), 64'(k == int'(BEATS) - 1));
            if (k != int'(BEATS) - 1) repeat (r.gap) step();
        end
        chk($sformatf("v%0d_addr", r.id), 64'(wb_addr), 64'(r.exp_addr));
        chk_vec($sformatf("v%0d_data", r.id), r.base);
`ifdef JOIN_LANE_MASK_EN
        chk($sformatf("v%0d_wemask", r.id), 64'(we_mask), 64'(20'hFFFFF));
`endif
        repeat (r.hold) begin
            in_valid = 1'b1;
            chunk    = mk_chunk(32'hDEAD_0000, 0);
            addr     = ~r.addr;
            step();
        end
        in_valid = 1'b0;
        if (r.hold > 0) begin
            chk($sformatf("v%0d_hold_valid", r.id), 64'(wb_valid), 64'(1));
            chk($sformatf("v%0d_hold_ready", r.id), 64'(in_ready), 64'(0));
            chk_vec($sformatf("v%0d_hold_data", r.id), r.base);
            chk($sformatf("v%0d_hold_addr", r.id), 64'(wb_addr), 64'(r.exp_addr));
        end else begin
            chk($sformatf("v%0d_ready_low", r.id), 64'(in_ready), 64'(0));
        end
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk($sformatf("v%0d_rel_valid", r.id), 64'(wb_valid), 64'(0));
        chk($sformatf("v%0d_rel_ready", r.id), 64'(in_ready), 64'(1));
    endtask

    vec_rec_t     tbl[4];
    vec_rec_t     rec;
    logic [N-1:0] prev_base;

    initial begin
        tbl[0] = '{0, 5'd7,  32'h0000_0000, 0, 0,  5'd7};
        tbl[1] = '{1, 5'd7,  32'h0000_0100, 0, 10, 5'd7};
        tbl[2] = '{2, 5'd7,  32'h0000_0000, 1, 0,  5'd7};
        tbl[3] = '{3, 5'd21, 32'hA000_0000, 2, 3,  5'd21};

        #12;
        rst = 1'b0;
        #2;
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_valid", 64'(wb_valid), 64'(0));
        chk("rst_addr", 64'(wb_addr), 64'(0));
        chk("rst_data_nonzero", 64'(wd != '0), 64'(0));
`ifdef JOIN_LANE_MASK_EN
        chk("rst_wemask", 64'(we_mask), 64'(0));
`endif

        for (int t = 0; t < 4; t++) run_vec(tbl[t]);
        prev_base = tbl[3].base;

        // Abort while beat 3 is offered: partial vector dropped, stored elements kept.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            chunk    = mk_chunk(32'd300, k);
            addr     = 5'd9;
            step();
        end
        chunk = mk_chunk(32'd300, 3);
        abort = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("abort_valid", 64'(wb_valid), 64'(0));
        chk("abort_ready", 64'(in_ready), 64'(1));
        chk("abort_keep_e5", 64'(wd[5]), 64'(32'd305));
        chk("abort_stale_e12", 64'(wd[12]), 64'(prev_base + 32'd12));
        rec = '{4, 5'd3, 32'h0000_0200, 0, 0, 5'd3};
        run_vec(rec);

        // Reset in the middle of a vector clears outputs at once.
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            chunk    = mk_chunk(32'd700, k);
            addr     = 5'd11;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_data_nonzero", 64'(wd != '0), 64'(0));
        chk("midrst_addr", 64'(wb_addr), 64'(0));
        chk("midrst_valid", 64'(wb_valid), 64'(0));
        #2;
        rst = 1'b0;
        step();
        chk("midrst_ready", 64'(in_ready), 64'(1));
        rec = '{5, 5'd13, 32'h0000_0400, 0, 0, 5'd13};
        run_vec(rec);
        prev_base = 32'h0000_0400;

`ifdef JOIN_LANE_MASK_EN
        // Lanes 1 and 3 masked: odd elements keep the previous vector's values.
        lane_mask = 4'b0101;
        for (int k = 0; k < int'(BEATS); k++) begin
            in_valid = 1'b1;
            chunk    = mk_chunk(32'd500, k);
            addr     = 5'd2;
            step();
        end
        in_valid = 1'b0;
        chk("mask_valid", 64'(wb_valid), 64'(1));
        chk("mask_wemask", 64'(we_mask), 64'(20'h55555));
        begin
            int           bad = 0;
            logic [N-1:0] exp_e;
            for (int i = int'(V) - 1; i >= 0; i--) begin
                exp_e = (i % 2 == 0) ? 32'd500 + N'(i) : prev_base + N'(i);
                if (wd[i] !== exp_e) bad = i;
            end
            exp_e = (bad % 2 == 0) ? 32'd500 + N'(bad) : prev_base + N'(bad);
            chk("mask_data", 64'(wd[bad]), 64'(exp_e));
        end
        wb_ready = 1'b1;
        step();
        wb_ready  = 1'b0;
        lane_mask = '1;
        chk("mask_rel_valid", 64'(wb_valid), 64'(0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
